mac_engine_vec: RTL and testbench

Parametrised successor to the single-lane MAC datapath. Consumes NB_LANES parallel signed a/b operand streams and an optional c bias stream, and runs a job of len_i beats. Each job operates in one of two modes: element-wise multiply, or lane-wise scalar product with bias. Adds a job FSM, beat counter, done pulse, soft clear and optional saturation. Sits between hwpe streamer sources/sink and the accelerator controller.

---
 rtl/mac_engine_vec.sv | 233 +++++++++++++++++++++++
 tb/tb_mac_engine_vec.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_engine_vec.sv
// Multi-lane signed MAC engine: element-wise multiply or biased scalar product per job.
// Define MAC_ENGINE_SATURATE_EN to clamp lane results and expose the sticky sat_o flag.
//   state   | meaning
//   IDLE    | waiting for start_i
//   LOAD_C  | waiting for the per-lane bias beat (scalar mode)
//   RUN     | consuming a/b beats
//   DRAIN   | emptying the product/accumulator pipeline
//   DONE    | one-cycle completion pulse
module mac_engine_vec #(
   parameter int NB_LANES   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic                           start_i,
   input  logic [CNT_WIDTH-1:0]           len_i,
   input  logic                           simple_mul_i,
   input  logic [5:0]                     shift_i,
   input  logic [NB_LANES*DATA_WIDTH-1:0] a_data_i,
   input  logic                           a_valid_i,
   output logic                           a_ready_o,
   input  logic [NB_LANES*DATA_WIDTH-1:0] b_data_i,
   input  logic                           b_valid_i,
   output logic                           b_ready_o,
   input  logic [NB_LANES*DATA_WIDTH-1:0] c_data_i,
   input  logic                           c_valid_i,
   output logic                           c_ready_o,
   output logic [NB_LANES*OUT_WIDTH-1:0]  d_data_o,
   output logic                           d_valid_o,
   input  logic                           d_ready_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [CNT_WIDTH-1:0]           beat_cnt_o
`ifdef MAC_ENGINE_SATURATE_EN
   ,
   output logic                           sat_o
`endif
);

   localparam int MULT_WIDTH = 2*DATA_WIDTH;
   localparam int ACC_WIDTH  = 2*DATA_WIDTH + CNT_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_C,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [CNT_WIDTH-1:0]         len_q, len_d;
   logic [CNT_WIDTH-1:0]         beat_cnt_q, beat_cnt_d;
   logic                         simple_q, simple_d;
   logic [5:0]                   shift_q, shift_d;
   logic                         mult_valid_q, mult_valid_d;
   logic signed [MULT_WIDTH-1:0] mult_q [NB_LANES];
   logic signed [MULT_WIDTH-1:0] mult_d [NB_LANES];
   logic signed [ACC_WIDTH-1:0]  acc_q  [NB_LANES];
   logic signed [ACC_WIDTH-1:0]  acc_d  [NB_LANES];
`ifdef MAC_ENGINE_SATURATE_EN
   logic                         sat_q, sat_d;
   logic signed [ACC_WIDTH-1:0]  res_shift [NB_LANES];
   logic [NB_LANES-1:0]          lane_clamp;
`endif

   logic signed [ACC_WIDTH-1:0]  lane_src [NB_LANES];
   logic [OUT_WIDTH-1:0]         lane_out [NB_LANES];
   logic                         d_hs;
   logic                         ab_hs;
   logic                         mult_consumed;
   logic                         mult_ready;

   // Result conversion: simple mode forwards the product, scalar mode the accumulator.
   always_comb begin
      for (int l = 0; l < NB_LANES; l++) begin
         lane_src[l] = simple_q ? {{(ACC_WIDTH-MULT_WIDTH){mult_q[l][MULT_WIDTH-1]}}, mult_q[l]}
                                : acc_q[l];
`ifdef MAC_ENGINE_SATURATE_EN
         res_shift[l]  = lane_src[l] >>> shift_q;
         lane_clamp[l] = (|res_shift[l][ACC_WIDTH-1:OUT_WIDTH-1]) &
                         ~(&res_shift[l][ACC_WIDTH-1:OUT_WIDTH-1]);
         if (lane_clamp[l]) begin
            lane_out[l] = res_shift[l][ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
         end else begin
            lane_out[l] = res_shift[l][OUT_WIDTH-1:0];
         end
`else
         lane_out[l] = OUT_WIDTH'(lane_src[l] >>> shift_q);
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      simple_d     = simple_q;
      shift_d      = shift_q;
      mult_valid_d = mult_valid_q;
      mult_d       = mult_q;
      acc_d        = acc_q;
      a_ready_o    = 1'b0;
      b_ready_o    = 1'b0;
      c_ready_o    = 1'b0;
      done_o       = 1'b0;
      busy_o       = (state_q != ST_IDLE);
      beat_cnt_o   = beat_cnt_q;
      d_data_o     = '0;

      if (simple_q) begin
         d_valid_o = mult_valid_q && (state_q == ST_RUN || state_q == ST_DRAIN);
      end else begin
         d_valid_o = (state_q == ST_DRAIN) && !mult_valid_q;
      end
      d_hs = d_valid_o && d_ready_i;

      if (d_valid_o) begin
         for (int l = 0; l < NB_LANES; l++) begin
            d_data_o[l*OUT_WIDTH +: OUT_WIDTH] = lane_out[l];
         end
      end

      // Scalar mode drains the product register into the accumulator every cycle.
      mult_consumed = mult_valid_q && (simple_q ? d_hs : 1'b1);
      mult_ready    = !mult_valid_q || mult_consumed;
      ab_hs         = (state_q == ST_RUN) && a_valid_i && b_valid_i && mult_ready;
      a_ready_o     = ab_hs;
      b_ready_o     = ab_hs;

      if (ab_hs) begin
         for (int l = 0; l < NB_LANES; l++) begin
            mult_d[l] = $signed(a_data_i[l*DATA_WIDTH +: DATA_WIDTH]) *
                        $signed(b_data_i[l*DATA_WIDTH +: DATA_WIDTH]);
         end
         mult_valid_d = 1'b1;
      end else if (mult_consumed) begin
         mult_valid_d = 1'b0;
      end

      if (!simple_q && mult_valid_q) begin
         for (int l = 0; l < NB_LANES; l++) begin
            acc_d[l] = acc_q[l] + {{(ACC_WIDTH-MULT_WIDTH){mult_q[l][MULT_WIDTH-1]}}, mult_q[l]};
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d      = (len_i == '0) ? CNT_WIDTH'(1) : len_i;
               simple_d   = simple_mul_i;
               shift_d    = shift_i;
               beat_cnt_d = '0;
               state_d    = simple_mul_i ? ST_RUN : ST_LOAD_C;
            end
         end
         ST_LOAD_C: begin
            c_ready_o = 1'b1;
            if (c_valid_i) begin
               for (int l = 0; l < NB_LANES; l++) begin
                  acc_d[l] = {{(ACC_WIDTH-DATA_WIDTH){c_data_i[l*DATA_WIDTH+DATA_WIDTH-1]}},
                              c_data_i[l*DATA_WIDTH +: DATA_WIDTH]} <<< shift_q;
               end
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ab_hs) begin
               beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
               if (beat_cnt_d == len_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (d_hs) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef MAC_ENGINE_SATURATE_EN
      sat_d = sat_q;
      if (state_q == ST_IDLE && start_i) begin
         sat_d = 1'b0;
      end else if (d_hs && (|lane_clamp)) begin
         sat_d = 1'b1;
      end
      sat_o = sat_q;
`endif
   end

   // Soft clear shares the reset path; configuration is only captured at start.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         simple_q     <= 1'b0;
         shift_q      <= '0;
         mult_valid_q <= 1'b0;
         for (int l = 0; l < NB_LANES; l++) begin
            mult_q[l] <= '0;
            acc_q[l]  <= '0;
         end
`ifdef MAC_ENGINE_SATURATE_EN
         sat_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         simple_q     <= simple_d;
         shift_q      <= shift_d;
         mult_valid_q <= mult_valid_d;
         mult_q       <= mult_d;
         acc_q        <= acc_d;
`ifdef MAC_ENGINE_SATURATE_EN
         sat_q        <= sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_mac_engine_vec.sv
// Scoreboard bench for mac_engine_vec: directed jobs push expected d beats, a monitor pops them.
module tb_mac_engine_vec;
   localparam int NB = 4;
   localparam int DW = 32;
   localparam int OW = 32;
   localparam int CW = 16;

   logic           clk_i;
   logic           rst_i, clear_i, start_i, simple_mul_i;
   logic [CW-1:0]  len_i;
   logic [5:0]     shift_i;
   logic [NB*DW-1:0] a_data_i, b_data_i, c_data_i;
   logic           a_valid_i, b_valid_i, c_valid_i;
   logic           a_ready_o, b_ready_o, c_ready_o;
   logic [NB*OW-1:0] d_data_o;
   logic           d_valid_o, d_ready_i, busy_o, done_o;
   logic [CW-1:0]  beat_cnt_o;
`ifdef MAC_ENGINE_SATURATE_EN
   logic           sat_o;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_hs_cyc = -10;
   int d_beats = 0;
   int rdy_mode = 0;
   logic [NB*OW-1:0] exp_q [$];
   logic             mon_stall = 1'b0;
   logic [NB*OW-1:0] mon_held = '0;

   mac_engine_vec #(.NB_LANES(NB), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
      .len_i(len_i), .simple_mul_i(simple_mul_i), .shift_i(shift_i),
      .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
      .b_data_i(b_data_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .c_data_i(c_data_i), .c_valid_i(c_valid_i), .c_ready_o(c_ready_o),
      .d_data_o(d_data_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
      .busy_o(busy_o), .done_o(done_o), .beat_cnt_o(beat_cnt_o)
`ifdef MAC_ENGINE_SATURATE_EN
      , .sat_o(sat_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial forever begin
      @(posedge clk_i);
      cyc = cyc + 1;
   end

   initial begin
      d_ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #2;
         case (rdy_mode)
            0:       d_ready_i = 1'b1;
            1:       d_ready_i = 1'($urandom_range(0, 1));
            default: d_ready_i = 1'b0;
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each d handshake and checks hold-while-stalled.
   initial forever begin
      @(negedge clk_i);
      if (rst_i || clear_i) begin
         mon_stall = 1'b0;
      end else begin
         if (mon_stall) begin
            check("d_hold_valid", d_valid_o, 1'b1);
            check("d_hold_data", d_data_o, mon_held);
         end
         if (d_valid_o && d_ready_i) begin
            d_beats++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL d_unexpected actual=%h required=no_beat", d_data_o);
            end else begin
               check("d_data", d_data_o, exp_q.pop_front());
            end
         end
         mon_stall = d_valid_o && !d_ready_i;
         mon_held  = d_data_o;
      end
   end

   function automatic logic [127:0] rep4(input logic [31:0] v);
      return {v, v, v, v};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input int len, input logic simple, input logic [5:0] sh);
      len_i        = CW'(len);
      simple_mul_i = simple;
      shift_i      = sh;
      start_i      = 1'b1;
      step();
      start_i      = 1'b0;
   endtask

   task automatic send_c(input logic [127:0] c);
      c_data_i  = c;
      c_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (c_ready_o) begin
            step();
            c_valid_i = 1'b0;
            return;
         end
         step();
      end
      c_valid_i = 1'b0;
      checks++;
      errors++;
      $display("FAIL c_handshake_timeout actual=no_ready required=ready");
   endtask

   task automatic send_ab(input logic [127:0] a, input logic [127:0] b);
      a_data_i  = a;
      b_data_i  = b;
      a_valid_i = 1'b1;
      b_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (a_ready_o && b_ready_o) begin
            step();
            a_valid_i = 1'b0;
            b_valid_i = 1'b0;
            return;
         end
         step();
      end
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
      checks++;
      errors++;
      $display("FAIL ab_handshake_timeout actual=no_ready required=ready");
   endtask

   task automatic wait_done(input string name, input int exp_beats);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (done_o) break;
      end
      check({name, "_done_seen"}, done_o, 1'b1);
      check({name, "_done_latency"}, cyc, last_hs_cyc + 1);
      check({name, "_beat_cnt"}, beat_cnt_o, CW'(exp_beats));
      step();
      @(negedge clk_i);
      check({name, "_done_width"}, done_o, 1'b0);
      check({name, "_idle_busy"}, busy_o, 1'b0);
      step();
   endtask

   int ta [16][NB];
   int tb [16][NB];
   int tc [NB];

   initial begin
      logic [127:0] a_v, b_v, e_v;
      longint acc;
      int beats0;

      rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; simple_mul_i = 1'b0;
      len_i = '0; shift_i = '0;
      a_data_i = '0; b_data_i = '0; c_data_i = '0;
      a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
      repeat (3) step();
      @(negedge clk_i);
      check("rst_busy", busy_o, 1'b0);
      check("rst_d_valid", d_valid_o, 1'b0);
      check("rst_beat_cnt", beat_cnt_o, '0);
      check("rst_done", done_o, 1'b0);
      check("rst_c_ready", c_ready_o, 1'b0);
      check("rst_d_data", d_data_o, '0);
      step();
      rst_i = 1'b0;
      step();

      // 1: reset in the middle of a scalar job, then a one-beat simple job
      start_job(8, 1'b0, 6'd0);
      send_c('0);
      repeat (3) send_ab(rep4(32'd1), rep4(32'd1));
      @(negedge clk_i);
      check("t1_beats_before_rst", beat_cnt_o, CW'(3));
      step();
      rst_i = 1'b1;
      step();
      step();
      @(negedge clk_i);
      check("t1_rst_busy", busy_o, 1'b0);
      check("t1_rst_d_valid", d_valid_o, 1'b0);
      check("t1_rst_beat_cnt", beat_cnt_o, '0);
      step();
      rst_i = 1'b0;
      step();
      start_job(1, 1'b1, 6'd0);
      exp_q.push_back(rep4(32'd6));
      send_ab(rep4(32'd2), rep4(32'd3));
      wait_done("t1", 1);

      // 2: scalar product with bias 10; lane l uses b+l so lane l = 80 + 10*l
      start_job(4, 1'b0, 6'd0);
      exp_q.push_back({32'd110, 32'd100, 32'd90, 32'd80});
      send_c(rep4(32'd10));
      for (int i = 0; i < 4; i++) begin
         a_v = rep4(32'(i + 1));
         b_v = {32'(i + 8), 32'(i + 7), 32'(i + 6), 32'(i + 5)};
         send_ab(a_v, b_v);
      end
      wait_done("t2", 4);

      // 3: simple mode with shift, consumer stalls on beat 2
      start_job(3, 1'b1, 6'd2);
      repeat (3) exp_q.push_back(rep4(32'hFFFF_FFFA));
      send_ab(rep4(-32'sd8), rep4(32'd3));
      step();
      rdy_mode = 2;
      send_ab(rep4(-32'sd8), rep4(32'd3));
      a_valid_i = 1'b1;
      b_valid_i = 1'b1;
      repeat (5) begin
         @(negedge clk_i);
         check("t3_ab_blocked", a_ready_o, 1'b0);
         check("t3_d_pending", d_valid_o, 1'b1);
         step();
      end
      rdy_mode = 0;
      send_ab(rep4(-32'sd8), rep4(32'd3));
      wait_done("t3", 3);

      // 4: scalar len=16 with bubbles, random d_ready and an ignored start pulse
      rdy_mode = 1;
      for (int l = 0; l < NB; l++) tc[l] = int'($urandom_range(0, 2000)) - 1000;
      for (int i = 0; i < 16; i++) begin
         for (int l = 0; l < NB; l++) begin
            ta[i][l] = int'($urandom_range(0, 2000)) - 1000;
            tb[i][l] = int'($urandom_range(0, 2000)) - 1000;
         end
      end
      e_v = '0;
      for (int l = 0; l < NB; l++) begin
         acc = longint'(tc[l]) * 8;
         for (int i = 0; i < 16; i++) acc += longint'(ta[i][l]) * longint'(tb[i][l]);
         acc = acc >>> 3;
         e_v[l*OW +: OW] = acc[OW-1:0];
      end
      start_job(16, 1'b0, 6'd3);
      exp_q.push_back(e_v);
      for (int l = 0; l < NB; l++) c_data_i[l*DW +: DW] = 32'(tc[l]);
      send_c(c_data_i);
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) step();
         if (i == 5) begin
            len_i = CW'(2);
            simple_mul_i = 1'b1;
            start_i = 1'b1;
            step();
            start_i = 1'b0;
         end
         for (int l = 0; l < NB; l++) begin
            a_v[l*DW +: DW] = 32'(ta[i][l]);
            b_v[l*DW +: DW] = 32'(tb[i][l]);
         end
         send_ab(a_v, b_v);
      end
      wait_done("t4", 16);
      rdy_mode = 0;
      step();

      // 5: large operands overflow the output width
      start_job(2, 1'b0, 6'd0);
`ifdef MAC_ENGINE_SATURATE_EN
      exp_q.push_back(rep4(32'h7FFF_FFFF));
`else
      exp_q.push_back(rep4(32'h0000_0002));
`endif
      send_c('0);
      repeat (2) send_ab(rep4(32'h7FFF_FFFF), rep4(32'h7FFF_FFFF));
      wait_done("t5", 2);
`ifdef MAC_ENGINE_SATURATE_EN
      check("t5_sat", sat_o, 1'b1);
`endif

      // 6: len 0 runs one beat; clear beats a simultaneous start
      beats0 = d_beats;
      start_job(0, 1'b1, 6'd0);
      exp_q.push_back(rep4(32'd20));
      send_ab(rep4(32'd4), rep4(32'd5));
      wait_done("t6", 1);
      check("t6_one_beat", d_beats - beats0, 1);
      len_i = CW'(4);
      simple_mul_i = 1'b0;
      clear_i = 1'b1;
      start_i = 1'b1;
      step();
      clear_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk_i);
      check("t6_clear_busy", busy_o, 1'b0);
      step();
      @(negedge clk_i);
      check("t6_clear_busy2", busy_o, 1'b0);
      check("t6_clear_c_ready", c_ready_o, 1'b0);
      step();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
